manchester_spi_rx: RTL

//  Link receiver paired with the Manchester SPI transmitter: takes spi_clk/spi_en/spi_data off the wire.

---
 rtl/manchester_spi_pkg.sv | 14 +
 rtl/manchester_rx_fifo.sv | 47 ++++
 rtl/manchester_spi_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/manchester_spi_pkg.sv
// Shared definitions for the Manchester SPI link (receiver and transmitter).
package manchester_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H0   = 2'd1,
    H1   = 2'd2
  } rx_state_t;

  localparam logic [1:0]  SYM_ONE    = 2'b10;
  localparam logic [1:0]  SYM_ZERO   = 2'b01;
  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/manchester_rx_fifo.sv
// First-word-fall-through output FIFO for the Manchester SPI receiver.
module manchester_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              do_pop;
  logic              do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/manchester_spi_rx.sv
// Manchester SPI link receiver: synchronize, decode half-bit symbols, assemble LSB-first bytes.
// Define RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO instead of a single register.
module manchester_spi_rx
  import manchester_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_en,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  output logic              err_code,
  output logic              err_frame,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] clk_sync, en_sync, data_sync;
  logic                   sclk_d;
  logic                   sync_clk, sync_en, sync_data, sclk_rise;

  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n, push_data;
  logic              half0, half0_n;
  logic              push, code_err, frame_err;
  logic              pop, store_full;
  logic [1:0]        sym;

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_en   = en_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign sclk_rise = sync_clk & ~sclk_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync  <= '0;
      en_sync   <= '0;
      data_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], spi_en};
      data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
      sclk_d    <= sync_clk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      half0   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      half0   <= half0_n;
    end
  end

  assign sym       = {half0, sync_data};
  assign push_data = {(sym == SYM_ONE), shreg[DATA_W-1:1]};

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    half0_n   = half0;
    push      = 1'b0;
    code_err  = 1'b0;
    frame_err = 1'b0;
    if (sclk_rise) begin
      unique case (state)
        IDLE: begin
          if (sync_en) begin
            half0_n = sync_data;
            state_n = H1;
          end
        end
        H0: begin
          if (sync_en) begin
            half0_n = sync_data;
            state_n = H1;
          end else begin
            frame_err = (bit_cnt != '0);
            bit_cnt_n = '0;
            state_n   = IDLE;
          end
        end
        H1: begin
          state_n = H0;
          if (sym == SYM_ONE || sym == SYM_ZERO) begin
            shreg_n = push_data;
            if (bit_cnt == LAST_BIT) begin
              push      = 1'b1;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end else begin
            code_err  = 1'b1;
            bit_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign pop     = rx_valid & rx_ready;
  assign rx_busy = (state != IDLE);

`ifdef RX_FIFO_EN
  manchester_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (store_full),
    .rd_data  (rx_data),
    .valid    (rx_valid)
  );
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (push && (!rx_valid || pop)) begin
      rx_data  <= push_data;
      rx_valid <= 1'b1;
    end else if (pop) begin
      rx_valid <= 1'b0;
    end
  end

  assign store_full = rx_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_code  <= 1'b0;
      err_frame <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      err_code  <= code_err;
      err_frame <= frame_err;
      overrun   <= push & store_full & ~pop;
    end
  end

endmodule
